// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for a shared combinational ALU with a registered response.
// Build option: define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority (no round-robin pointer).
module alu_arbiter #(
   parameter int N_BITS   = 32,
   parameter int N_OPCODE = 6
) (
   input  logic                i_clock,
   input  logic                i_reset_n,
   input  logic                i_req0_valid,
   input  logic [N_BITS-1:0]   i_req0_datoA,
   input  logic [N_BITS-1:0]   i_req0_datoB,
   input  logic [N_OPCODE-1:0] i_req0_opcode,
   output logic                o_req0_ready,
   input  logic                i_req1_valid,
   input  logic [N_BITS-1:0]   i_req1_datoA,
   input  logic [N_BITS-1:0]   i_req1_datoB,
   input  logic [N_OPCODE-1:0] i_req1_opcode,
   output logic                o_req1_ready,
   output logic [N_BITS-1:0]   o_alu_datoA,
   output logic [N_BITS-1:0]   o_alu_datoB,
   output logic [N_OPCODE-1:0] o_alu_opcode,
   input  logic [N_BITS-1:0]   i_alu_result,
   input  logic                i_alu_cero,
   output logic                o_rsp_valid,
   output logic                o_rsp_id,
   output logic [N_BITS-1:0]   o_rsp_result,
   output logic                o_rsp_cero,
   input  logic                i_rsp_ready,
   output logic                o_busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nx;
   logic [N_BITS-1:0] dat_a, dat_b, res;
   logic [N_OPCODE-1:0] opc;
   logic id, cero, gnt0, gnt1, idle;
   // reset gates the grants so ready stays low while i_reset_n is held low
   assign idle = i_reset_n && state == IDLE;
`ifdef ALU_ARB_FIXED_PRIO_EN
   assign gnt0 = idle && i_req0_valid;
   assign gnt1 = idle && i_req1_valid && !i_req0_valid;
`else
   logic ptr;
   assign gnt0 = idle && i_req0_valid && (!i_req1_valid || !ptr);
   assign gnt1 = idle && i_req1_valid && (!i_req0_valid || ptr);
   always_ff @(posedge i_clock or negedge i_reset_n)
      if (!i_reset_n) ptr <= 1'b0;
      else if (gnt0 || gnt1) ptr <= gnt0;
`endif
   always_comb begin
      state_nx = state;
      o_req0_ready = gnt0;
      o_req1_ready = gnt1;
      o_busy = state != IDLE;
      o_rsp_valid = state == RESP;
      if (state == IDLE) state_nx = (gnt0 || gnt1) ? EXEC : IDLE;
      else if (state == EXEC) state_nx = RESP;
      else state_nx = i_rsp_ready ? IDLE : RESP;
   end
   always_ff @(posedge i_clock or negedge i_reset_n)
      if (!i_reset_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge i_clock or negedge i_reset_n)
      if (!i_reset_n) begin
         dat_a <= '0;
         dat_b <= '0;
         opc <= '0;
         id <= 1'b0;
         res <= '0;
         cero <= 1'b0;
      end else begin
         if (gnt0 || gnt1) begin
            dat_a <= gnt1 ? i_req1_datoA : i_req0_datoA;
            dat_b <= gnt1 ? i_req1_datoB : i_req0_datoB;
            opc <= gnt1 ? i_req1_opcode : i_req0_opcode;
            id <= gnt1;
         end
         if (state == EXEC) begin
            res <= i_alu_result;
            cero <= i_alu_cero;
         end
      end
   assign o_alu_datoA = dat_a;
   assign o_alu_datoB = dat_b;
   assign o_alu_opcode = opc;
   assign o_rsp_id = id;
   assign o_rsp_result = res;
   assign o_rsp_cero = cero;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: random and directed stimulus against a transaction-level arbiter model.
module tb_alu_arbiter;
   localparam logic [5:0] OP_ADD = 6'b000010, OP_SUB = 6'b001101, OP_OR = 6'b000001, OP_AND = 6'b100100;
   logic clk = 1'b0, rst_n = 1'b0;
   logic v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
   logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic [5:0] op0 = '0, op1 = '0;
   logic rdy0, rdy1, rsp_valid, rsp_id, rsp_cero, busy, alu_cero;
   logic [31:0] alu_a, alu_b, alu_res, rsp_result;
   logic [5:0] alu_op;
   int checks = 0, errors = 0;
   int m_phase = 0;
   int m_ptr = 0, m_id = 0;
   logic [31:0] m_a = '0, m_b = '0, m_res = '0;
   logic [5:0] m_op = '0;
   logic m_cero = 1'b0;
   always #5 clk = ~clk;
   alu_arbiter dut (
      .i_clock(clk), .i_reset_n(rst_n),
      .i_req0_valid(v0), .i_req0_datoA(a0), .i_req0_datoB(b0), .i_req0_opcode(op0), .o_req0_ready(rdy0),
      .i_req1_valid(v1), .i_req1_datoA(a1), .i_req1_datoB(b1), .i_req1_opcode(op1), .o_req1_ready(rdy1),
      .o_alu_datoA(alu_a), .o_alu_datoB(alu_b), .o_alu_opcode(alu_op),
      .i_alu_result(alu_res), .i_alu_cero(alu_cero),
      .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_result(rsp_result), .o_rsp_cero(rsp_cero),
      .i_rsp_ready(rr), .o_busy(busy)
   );
   function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
      return op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_OR ? a | b :
             op == OP_AND ? a & b : a ^ b ^ {26'b0, op};
   endfunction
   always_comb begin
      alu_res = alu(alu_a, alu_b, alu_op);
      alu_cero = alu_res == '0;
   end
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      m_phase = 0; m_ptr = 0; m_id = 0;
      m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_cero = 1'b0;
   endtask
   task automatic step(input logic q0, input logic [31:0] x0, input logic [31:0] y0, input logic [5:0] p0,
                       input logic q1, input logic [31:0] x1, input logic [31:0] y1, input logic [5:0] p1,
                       input logic take);
      int w;
      @(negedge clk);
      v0 = q0; a0 = x0; b0 = y0; op0 = p0;
      v1 = q1; a1 = x1; b1 = y1; op1 = p1; rr = take;
      #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = q0 ? 0 : 1;
`else
      w = (q0 && q1) ? m_ptr : (q1 ? 1 : 0);
`endif
      chk("ready0", rdy0, m_phase == 0 && (q0 || q1) && w == 0);
      chk("ready1", rdy1, m_phase == 0 && (q0 || q1) && w == 1);
      chk("rsp_valid", rsp_valid, m_phase == 2);
      chk("busy", busy, m_phase != 0);
      chk("rsp_id", rsp_id, m_id[0]);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", alu_op, m_op);
      if (m_phase == 2) begin
         chk("rsp_result", rsp_result, m_res);
         chk("rsp_cero", rsp_cero, m_cero);
      end
      @(posedge clk);
      if (m_phase == 2) m_phase = take ? 0 : 2;
      else if (m_phase == 1) begin
         m_res = alu(m_a, m_b, m_op);
         m_cero = m_res == '0;
         m_phase = 2;
      end else if (q0 || q1) begin
         m_id = w;
         m_ptr = 1 - w;
         m_a = w ? x1 : x0; m_b = w ? y1 : y0; m_op = w ? p1 : p0;
         m_phase = 1;
      end
   endtask
   task automatic idle_step(input logic take);
      step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, take);
   endtask
   task automatic reset_pulse();
      @(negedge clk);
      v0 = 1'b0; v1 = 1'b0; rr = 1'b0; rst_n = 1'b0;
      #1;
      chk("rst_ready0", rdy0, 1'b0);
      chk("rst_ready1", rdy1, 1'b0);
      chk("rst_valid", rsp_valid, 1'b0);
      chk("rst_id", rsp_id, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_result", rsp_result, 32'h0);
      chk("rst_alu_a", alu_a, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      v0 = 1'b1; v1 = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready0", rdy0, 1'b0);
      chk("rst_ready1", rdy1, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", rsp_valid, 1'b0);
      v0 = 1'b0; v1 = 1'b0;
      rst_n = 1'b1;
      step(1'b1, 32'd5, 32'd7, OP_ADD, 1'b0, '0, '0, '0, 1'b0);
      idle_step(1'b0);
      #1;
      chk("add_valid", rsp_valid, 1'b1);
      chk("add_result", rsp_result, 32'd12);
      chk("add_cero", rsp_cero, 1'b0);
      chk("add_id", rsp_id, 1'b0);
      idle_step(1'b1);
      step(1'b0, '0, '0, '0, 1'b1, 32'd3, 32'd3, OP_SUB, 1'b0);
      idle_step(1'b0);
      #1;
      chk("sub_result", rsp_result, 32'd0);
      chk("sub_cero", rsp_cero, 1'b1);
      chk("sub_id", rsp_id, 1'b1);
      idle_step(1'b1);
      reset_pulse();
      repeat (12) step(1'b1, 32'd1, 32'd2, OP_ADD, 1'b1, 32'd9, 32'd4, OP_SUB, 1'b1);
      step(1'b1, 32'hF0, 32'h0F, OP_OR, 1'b0, '0, '0, '0, 1'b0);
      idle_step(1'b0);
      repeat (5) begin
         step(1'b1, 32'd1, 32'd1, OP_ADD, 1'b1, 32'd2, 32'd2, OP_ADD, 1'b0);
         chk("or_hold", rsp_result, 32'hFF);
      end
      idle_step(1'b1);
      #1;
      chk("or_release", busy, 1'b0);
      step(1'b0, '0, '0, '0, 1'b1, 32'd8, 32'd8, OP_AND, 1'b0);
      reset_pulse();
      idle_step(1'b0);
      idle_step(1'b0);
      step(1'b1, 32'd4, 32'd4, OP_ADD, 1'b1, 32'd6, 32'd6, OP_ADD, 1'b1);
      for (int i = 0; i < 400; i++) begin
         logic [5:0] ops [4];
         ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_OR; ops[3] = 6'($urandom);
         if ($urandom_range(0, 49) == 0) reset_pulse();
         else step(1'($urandom), 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), ops[$urandom_range(0, 3)],
                   1'($urandom), $urandom, 32'($urandom_range(0, 3)), ops[$urandom_range(0, 3)],
                   1'($urandom));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
